// File: rtl/lcd_pkg.sv
// Shared types, command bytes and character ROM for the status LCD.
// Helpers turn labels, mode names and clock fields into ASCII bytes.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        CLR_WAIT,
        REFRESH,
        IDLE
    } state_t;

    typedef enum logic [1:0] {
        SETUP,
        PULSE,
        HOLD
    } phase_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [4:0] hour;
        logic [5:0] minute;
        logic [5:0] second;
    } snap_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    localparam logic [47:0] LABEL_MODE = "MODE: ";
    localparam logic [47:0] LABEL_TIME = "TIME: ";

    localparam logic [79:0] NAME_DAY   = "DAY       ";
    localparam logic [79:0] NAME_NIGHT = "NIGHT     ";
    localparam logic [79:0] NAME_EMERG = "EMERGENCY ";
    localparam logic [79:0] NAME_ERROR = "ERROR     ";

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = CMD_FUNC_SET;
            2'd1:    c = CMD_DISP_ON;
            2'd2:    c = CMD_ENTRY;
            default: c = CMD_CLEAR;
        endcase
        return c;
    endfunction

    function automatic logic [79:0] mode_name(input logic [1:0] m);
        logic [79:0] n;
        case (m)
            2'd0:    n = NAME_DAY;
            2'd1:    n = NAME_NIGHT;
            2'd2:    n = NAME_EMERG;
            default: n = NAME_ERROR;
        endcase
        return n;
    endfunction

    // Character i of a 6-char label, leftmost first
    function automatic logic [7:0] label_char(
        input logic [47:0] s,
        input logic [3:0]  i
    );
        logic [47:0] t;
        t = s << {i, 3'b000};
        return t[47:40];
    endfunction

    // Character i of a 10-char name, leftmost first
    function automatic logic [7:0] name_char(
        input logic [79:0] s,
        input logic [3:0]  i
    );
        logic [79:0] t;
        t = s << {i, 3'b000};
        return t[79:72];
    endfunction

    // Two ASCII digits, or "--" when the value exceeds lim
    function automatic logic [15:0] two_digit(
        input logic [5:0] v,
        input logic [5:0] lim
    );
        logic [5:0] tens;
        logic [5:0] units;
        logic [15:0] r;
        tens  = v / 6'd10;
        units = v % 6'd10;
        if (v > lim) begin
            r = {CH_DASH, CH_DASH};
        end else begin
            r = {CH_ZERO + {2'b00, tens}, CH_ZERO + {2'b00, units}};
        end
        return r;
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            SETUP:   n = PULSE;
            PULSE:   n = HOLD;
            default: n = SETUP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lcd_status_display_char_gen.sv
// Maps a line/column position and the status snapshot to one ASCII byte.
// Line 0 shows the mode name, line 1 the time as HH:MM:SS.
module lcd_char_gen
    import lcd_pkg::*;
(
    input  logic       line,
    input  logic [3:0] index,
    input  snap_t      snap,
    output logic [7:0] char_o
);

    logic [15:0] hh;
    logic [15:0] mm;
    logic [15:0] ss;

    // Select the character for the requested screen position
    always_comb begin
        hh = two_digit({1'b0, snap.hour}, 6'd23);
        mm = two_digit(snap.minute, 6'd59);
        ss = two_digit(snap.second, 6'd59);
        char_o = CH_SPACE;
        if (!line) begin
            if (index < 4'd6) begin
                char_o = label_char(LABEL_MODE, index);
            end else begin
                char_o = name_char(mode_name(snap.mode), index - 4'd6);
            end
        end else begin
            case (index)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5:
                    char_o = label_char(LABEL_TIME, index);
                4'd6:    char_o = hh[15:8];
                4'd7:    char_o = hh[7:0];
                4'd8:    char_o = CH_COLON;
                4'd9:    char_o = mm[15:8];
                4'd10:   char_o = mm[7:0];
                4'd11:   char_o = CH_COLON;
                4'd12:   char_o = ss[15:8];
                4'd13:   char_o = ss[7:0];
                default: char_o = CH_SPACE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_status_display.sv
// HD44780 16x2 status display: power-up init, then periodic or requested
// refreshes of the mode line and the time line in 3-cycle byte transfers.
module lcd_status_display
    import lcd_pkg::*;
#(
    parameter int POWERUP_DELAY  = 20,
    parameter int CLEAR_WAIT     = 2,
    parameter int REFRESH_PERIOD = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       refresh_req,
    input  logic [1:0] mode,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       busy
);

    localparam logic [15:0] PWR_LAST    = 16'(POWERUP_DELAY - 1);
    localparam logic [15:0] CLR_LAST    = 16'(CLEAR_WAIT - 1);
    localparam logic [15:0] PERIOD_LAST = 16'(REFRESH_PERIOD - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] period_q, period_d;
    logic [3:0]  idx_q, idx_d;
    logic        line_q, line_d;
    logic        cmd_q, cmd_d;
    logic        pending_q, pending_d;
    snap_t       snap_q, snap_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;

    logic        go_refresh;
    logic        xfer;
    logic        first_cycle;
    logic [7:0]  gen_char;
    logic [7:0]  cur_byte;
    logic        cur_rs;

    lcd_char_gen u_char_gen (
        .line   (line_q),
        .index  (idx_q),
        .snap   (snap_q),
        .char_o (gen_char)
    );

    // Main sequencer: init steps, byte position and refresh launch
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        line_d     = line_q;
        cmd_d      = cmd_q;
        go_refresh = 1'b0;
        unique case (state_q)
            PWR_WAIT: begin
                if (timer_q == PWR_LAST) begin
                    state_d = INIT;
                    timer_d = '0;
                    idx_d   = '0;
                    phase_d = SETUP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            INIT: begin
                phase_d = next_phase(phase_q);
                if (phase_q == HOLD) begin
                    if (idx_q == 4'd3) begin
                        idx_d = '0;
                        if (CLEAR_WAIT == 0) begin
                            go_refresh = 1'b1;
                        end else begin
                            state_d = CLR_WAIT;
                            timer_d = '0;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            CLR_WAIT: begin
                if (timer_q == CLR_LAST) begin
                    go_refresh = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            REFRESH: begin
                phase_d = next_phase(phase_q);
                if (phase_q == HOLD) begin
                    if (cmd_q) begin
                        cmd_d = 1'b0;
                    end else if (idx_q == 4'd15) begin
                        idx_d = 4'd0;
                        if (line_q) begin
                            state_d = IDLE;
                        end else begin
                            line_d = 1'b1;
                            cmd_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            IDLE: begin
                if (refresh_req || pending_q ||
                    period_q == PERIOD_LAST) begin
                    go_refresh = 1'b1;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
        if (go_refresh) begin
            state_d = REFRESH;
            phase_d = SETUP;
            idx_d   = '0;
            line_d  = 1'b0;
            cmd_d   = 1'b1;
        end
    end

    // Period counter restarts at each refresh start and saturates
    always_comb begin
        period_d = period_q;
        if (go_refresh) begin
            period_d = '0;
        end else if (period_q != PERIOD_LAST) begin
            period_d = period_q + 16'd1;
        end
    end

    // One-deep request memory for requests arriving while busy
    always_comb begin
        pending_d = pending_q;
        if (state_q != IDLE && refresh_req) begin
            pending_d = 1'b1;
        end
        if (state_q == IDLE && go_refresh) begin
            pending_d = 1'b0;
        end
    end

    // Freeze the status inputs on the first refresh cycle
    always_comb begin
        first_cycle = (state_q == REFRESH) && cmd_q &&
                      !line_q && (phase_q == SETUP);
        snap_d = snap_q;
        if (first_cycle) begin
            snap_d = '{mode: mode, hour: hour,
                       minute: minute, second: second};
        end
    end

    // Byte for the current position; RS/DATA load at SETUP and then hold
    always_comb begin
        xfer     = (state_q == INIT) || (state_q == REFRESH);
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        if (state_q == INIT) begin
            cur_byte = init_cmd(idx_q[1:0]);
        end else if (state_q == REFRESH) begin
            if (cmd_q) begin
                cur_byte = line_q ? CMD_LINE2 : CMD_LINE1;
            end else begin
                cur_byte = gen_char;
                cur_rs   = 1'b1;
            end
        end
        data_d = data_q;
        rs_d   = rs_q;
        if (xfer && phase_q == SETUP) begin
            data_d = cur_byte;
            rs_d   = cur_rs;
        end
    end

    // State registers; reset aborts any transfer and restarts init
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= PWR_WAIT;
            phase_q   <= SETUP;
            timer_q   <= '0;
            period_q  <= '0;
            idx_q     <= '0;
            line_q    <= 1'b0;
            cmd_q     <= 1'b0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            data_q    <= '0;
            rs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            idx_q     <= idx_d;
            line_q    <= line_d;
            cmd_q     <= cmd_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
        end
    end

    assign LCD_E    = xfer && (phase_q == PULSE);
    assign LCD_RS   = rs_d;
    assign LCD_DATA = data_d;
    assign LCD_RW   = 1'b0;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_status_display.sv
// Directed bench for lcd_status_display: init stream, refresh content,
// request merging, auto refresh timing and reset during a transfer.
module tb_lcd_status_display;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       refresh_req = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [4:0] hour = 5'd0;
    logic [5:0] minute = 6'd0;
    logic [5:0] second = 6'd0;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rw_hi = 0;
    logic prev_e = 1'b0;
    logic [8:0] q[$];
    int qc[$];

    always #5 clock = ~clock;

    lcd_status_display #(
        .POWERUP_DELAY  (20),
        .CLEAR_WAIT     (2),
        .REFRESH_PERIOD (1000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .refresh_req (refresh_req),
        .mode        (mode),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .LCD_E       (LCD_E),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_DATA    (LCD_DATA),
        .busy        (busy)
    );

    task automatic chk(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (LCD_RW) rw_hi++;
        if (LCD_E) begin
            q.push_back({LCD_RS, LCD_DATA});
            qc.push_back(cyc);
        end
        if (prev_e && !LCD_E && q.size() > 0) begin
            chk("hold", 128'({LCD_RS, LCD_DATA}),
                128'(q[q.size()-1]));
        end
        prev_e = LCD_E;
    endtask

    task automatic wait_busy(
        input  logic lvl,
        input  int   bound,
        output int   at
    );
        int n;
        n = 0;
        while (busy !== lvl && n < bound) begin
            tick();
            n++;
        end
        chk("wait_busy", 128'(busy), 128'(lvl));
        at = cyc;
    endtask

    task automatic check_reset_outputs();
        chk("rst_e", 128'(LCD_E), 128'(0));
        chk("rst_rs", 128'(LCD_RS), 128'(0));
        chk("rst_rw", 128'(LCD_RW), 128'(0));
        chk("rst_data", 128'(LCD_DATA), 128'(0));
        chk("rst_busy", 128'(busy), 128'(1));
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
        prev_e = 1'b0;
        q.delete();
        qc.delete();
    endtask

    function automatic logic [127:0] line_at(input int base);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (base + i < q.size()) v = {v[119:0], q[base+i][7:0]};
            else v = {v[119:0], 8'h00};
        end
        return v;
    endfunction

    function automatic int rs_cnt(input int base);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (base + i < q.size() && q[base+i][8]) n++;
        end
        return n;
    endfunction

    initial begin
        int t;
        int sa;
        int sb;
        int n;
        int hi;
        logic [8:0] ib [4];
        ib = '{9'h038, 9'h00C, 9'h006, 9'h001};

        // Reset state
        mode = 2'd2;
        hour = 5'd13;
        minute = 6'd5;
        second = 6'd9;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        release_reset();

        // Power-up delay and first init strobe
        repeat (20) tick();
        chk("e_at_20", 128'(LCD_E), 128'(0));
        tick();
        chk("e_at_21", 128'(LCD_E), 128'(1));
        chk("first_byte", 128'({LCD_RS, LCD_DATA}), 128'(9'h038));

        // Init plus first refresh
        wait_busy(1'b0, 400, t);
        chk("busy_fall", 128'(t), 128'(136));
        chk("nbytes0", 128'(q.size()), 128'(38));
        for (int i = 0; i < 4; i++) begin
            chk("init_byte", 128'(q[i]), 128'(ib[i]));
        end
        chk("clr_gap", 128'(qc[4] - qc[3]), 128'(5));
        chk("cmd_l1", 128'(q[4]), 128'(9'h080));
        chk("line1_a", line_at(5), "MODE: EMERGENCY ");
        chk("rs_l1", 128'(rs_cnt(5)), 128'(16));
        chk("cmd_l2", 128'(q[21]), 128'(9'h0C0));
        chk("line2_a", line_at(22), "TIME: 13:05:09  ");
        chk("rs_l2", 128'(rs_cnt(22)), 128'(16));

        // Requested refresh with out-of-range fields
        q.delete();
        qc.delete();
        mode = 2'd3;
        hour = 5'd24;
        minute = 6'd60;
        second = 6'd7;
        refresh_req = 1'b1;
        tick();
        refresh_req = 1'b0;
        sa = cyc;
        chk("req_start", 128'(busy), 128'(1));
        repeat (20) tick();
        mode = 2'd0;
        hour = 5'd1;
        minute = 6'd2;
        second = 6'd3;
        repeat (3) begin
            refresh_req = 1'b1;
            tick();
            refresh_req = 1'b0;
            tick();
        end
        wait_busy(1'b0, 200, t);
        chk("a_len", 128'(t - sa), 128'(102));
        tick();
        chk("b_start", 128'(busy), 128'(1));
        sb = cyc;
        wait_busy(1'b0, 200, t);
        chk("b_len", 128'(t - sb), 128'(102));
        chk("nbytes_ab", 128'(q.size()), 128'(68));
        chk("line1_err", line_at(1), "MODE: ERROR     ");
        chk("line2_oor", line_at(18), "TIME: --:--:07  ");
        chk("line1_day", line_at(35), "MODE: DAY       ");
        chk("line2_b", line_at(52), "TIME: 01:02:03  ");

        // Only one extra refresh
        hi = 0;
        repeat (100) begin
            tick();
            if (busy) hi++;
        end
        chk("no_extra", 128'(hi), 128'(0));

        // Automatic refresh timing
        wait_busy(1'b1, 1200, t);
        chk("auto_start", 128'(t - sb), 128'(1000));

        // Reset in the middle of line 2
        repeat (60) tick();
        n = 0;
        while (!LCD_E && n < 10) begin
            tick();
            n++;
        end
        chk("e_before_rst", 128'(LCD_E), 128'(1));
        chk("in_line2", 128'(q.size() - 69 >= 18), 128'(1));
        #2;
        reset = 1'b1;
        prev_e = 1'b0;
        #1;
        check_reset_outputs();
        release_reset();
        n = 0;
        while (!LCD_E && n < 100) begin
            tick();
            n++;
        end
        chk("restart_cyc", 128'(cyc), 128'(21));
        chk("restart_byte", 128'({LCD_RS, LCD_DATA}), 128'(9'h038));
        chk("rw_low", 128'(rw_hi), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
